// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the command master: response codes,
// FSM state encoding and the UART register map it talks to.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [15:0] UART_RX_OFF  = 16'h0000;
    localparam logic [15:0] UART_TX_OFF  = 16'h0004;
    localparam logic [15:0] UART_DIV_OFF = 16'h0008;
    localparam logic [15:0] UART_CFG_OFF = 16'h000C;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WR_ADDR_DATA = 3'd1,
        ST_WR_RESP      = 3'd2,
        ST_RD_ADDR      = 3'd3,
        ST_RD_DATA      = 3'd4,
        ST_RESP         = 3'd5
    } state_e;

    // States in which the slave owes us a handshake; the watchdog runs here.
    function automatic logic is_bus_state(input state_e s);
        return (s == ST_WR_ADDR_DATA) || (s == ST_WR_RESP) ||
               (s == ST_RD_ADDR) || (s == ST_RD_DATA);
    endfunction

endpackage

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: one user command in, one AXI-Lite
// transaction out, one response back. A watchdog turns a dead slave into SLVERR.
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned P_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned P_M_AXI_ADDR_WIDTH = 16,
    parameter int unsigned P_TIMEOUT_CYCLES   = 1024
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              i_cmd_valid,
    output logic                              o_cmd_ready,
    input  logic                              i_cmd_wr,
    input  logic [P_M_AXI_ADDR_WIDTH-1:0]     i_cmd_addr,
    input  logic [P_M_AXI_DATA_WIDTH-1:0]     i_cmd_wdata,
    output logic                              o_rsp_valid,
    input  logic                              i_rsp_ready,
    output logic                              o_rsp_wr,
    output logic [P_M_AXI_DATA_WIDTH-1:0]     o_rsp_rdata,
    output logic [1:0]                        o_rsp_resp,
    output logic                              o_rsp_timeout,
    output logic                              o_busy,
    output logic [P_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [P_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [P_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    output logic [P_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    input  logic [P_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready
);

    localparam int unsigned CNT_W = (P_TIMEOUT_CYCLES > 0) ? $clog2(P_TIMEOUT_CYCLES + 1) : 1;
    localparam bit          WD_EN = (P_TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((P_TIMEOUT_CYCLES > 0) ? P_TIMEOUT_CYCLES - 1 : 0);

    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            cmd_ready_q, cmd_ready_d;
    logic                            busy_q, busy_d;
    logic                            wr_q, wr_d;
    logic [P_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [P_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                            awvalid_q, awvalid_d;
    logic                            wvalid_q, wvalid_d;
    logic                            aw_done_q, aw_done_d;
    logic                            w_done_q, w_done_d;
    logic                            bready_q, bready_d;
    logic                            arvalid_q, arvalid_d;
    logic                            rready_q, rready_d;
    logic                            rsp_valid_q, rsp_valid_d;
    logic [P_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                      rsp_resp_q, rsp_resp_d;
    logic                            rsp_timeout_q, rsp_timeout_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= RESP_OKAY;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_ready_d   = cmd_ready_q;
        busy_d        = busy_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    wr_d        = i_cmd_wr;
                    addr_d      = i_cmd_addr;
                    wdata_d     = i_cmd_wdata;
                    cnt_d       = '0;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    if (i_cmd_wr) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR_ADDR_DATA;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_ADDR;
                    end
                end
            end
            ST_WR_ADDR_DATA: begin
                // AW and W complete independently, in any order or together.
                if (awvalid_q && m_axi_awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && m_axi_wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (bready_q && m_axi_bvalid) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = m_axi_bresp;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end
            end
            ST_RD_ADDR: begin
                if (arvalid_q && m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (rready_q && m_axi_rvalid) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = m_axi_rdata;
                    rsp_resp_d    = m_axi_rresp;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Watchdog: saturating count, abort overrides any handshake this edge.
        if (is_bus_state(state_q)) begin
            if (cnt_q != CNT_LAST) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (WD_EN && (cnt_q == CNT_LAST)) begin
                awvalid_d     = 1'b0;
                wvalid_d      = 1'b0;
                bready_d      = 1'b0;
                arvalid_d     = 1'b0;
                rready_d      = 1'b0;
                rsp_valid_d   = 1'b1;
                rsp_rdata_d   = '0;
                rsp_resp_d    = RESP_SLVERR;
                rsp_timeout_d = 1'b1;
                state_d       = ST_RESP;
            end
        end
    end

    assign o_cmd_ready   = cmd_ready_q;
    assign o_busy        = busy_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_wr      = wr_q;
    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_resp    = rsp_resp_q;
    assign o_rsp_timeout = rsp_timeout_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: directed timing steps plus randomized command
// traffic against a behavioural AXI-Lite slave and a register-level reference.
module tb_axi_lite_cmd_master;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          i_cmd_valid, i_cmd_wr, i_rsp_ready;
  logic [AW-1:0] i_cmd_addr;
  logic [DW-1:0] i_cmd_wdata;
  logic          o_cmd_ready, o_rsp_valid, o_rsp_wr, o_rsp_timeout, o_busy;
  logic [DW-1:0] o_rsp_rdata;
  logic [1:0]    o_rsp_resp;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic [1:0]    m_axi_bresp, m_axi_rresp;
  logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic          m_axi_rvalid, m_axi_rready;

  axi_lite_cmd_master #(
    .P_M_AXI_DATA_WIDTH(DW), .P_M_AXI_ADDR_WIDTH(AW), .P_TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_wr(i_cmd_wr),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_wr(o_rsp_wr),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_resp(o_rsp_resp), .o_rsp_timeout(o_rsp_timeout),
    .o_busy(o_busy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Slave behaviour knobs, written only by the main sequence between commands.
  int         sl_aw_dly = 0, sl_w_dly = 0, sl_b_dly = 0, sl_ar_dly = 0, sl_r_dly = 0;
  logic [1:0] sl_bresp = 2'b00, sl_rresp = 2'b00;
  bit         sl_early = 1'b0, sl_dead = 1'b0;

  logic [AW-1:0] sl_awaddr;
  logic [DW-1:0] sl_wdata;
  logic [DW-1:0] sl_mem [4];
  int            b_ack_cnt;
  logic [DW-1:0] ref_mem [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  initial begin : slave_aw
    m_axi_awready = 1'b0;
    sl_awaddr = '0;
    forever begin
      @(posedge clock); #1;
      if (m_axi_awvalid && !sl_dead) begin
        for (int i = 0; i < sl_aw_dly; i++) begin @(posedge clock); #1; end
        if (m_axi_awvalid) begin
          m_axi_awready = 1'b1;
          sl_awaddr = m_axi_awaddr;
          @(posedge clock); #1;
          m_axi_awready = 1'b0;
        end
      end
    end
  end

  initial begin : slave_w
    m_axi_wready = 1'b0;
    sl_wdata = '0;
    forever begin
      @(posedge clock); #1;
      if (m_axi_wvalid && !sl_dead) begin
        for (int i = 0; i < sl_w_dly; i++) begin @(posedge clock); #1; end
        if (m_axi_wvalid) begin
          m_axi_wready = 1'b1;
          sl_wdata = m_axi_wdata;
          @(posedge clock); #1;
          m_axi_wready = 1'b0;
        end
      end
    end
  end

  initial begin : slave_b
    logic [1:0] resp;
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
    b_ack_cnt    = 0;
    for (int i = 0; i < 4; i++) sl_mem[i] = '0;
    forever begin
      @(posedge clock); #1;
      if (m_axi_bready && !sl_dead) begin
        for (int i = 0; i < sl_b_dly; i++) begin @(posedge clock); #1; end
        resp = sl_bresp;
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = resp;
        for (int k = 0; k < 30; k++) begin
          if (m_axi_bready) begin
            @(posedge clock); #1;
            b_ack_cnt++;
            if (resp == 2'b00) sl_mem[sl_awaddr[3:2]] = sl_wdata;
            break;
          end
          @(posedge clock); #1;
        end
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
      end
    end
  end

  initial begin : slave_r
    logic [1:0] idx;
    bit early;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    forever begin
      @(posedge clock); #1;
      if (m_axi_arvalid && !sl_dead) begin
        for (int i = 0; i < sl_ar_dly; i++) begin @(posedge clock); #1; end
        if (m_axi_arvalid) begin
          idx = m_axi_araddr[3:2];
          early = sl_early;
          m_axi_arready = 1'b1;
          if (early) begin
            m_axi_rvalid = 1'b1; m_axi_rdata = sl_mem[idx]; m_axi_rresp = sl_rresp;
          end
          @(posedge clock); #1;
          m_axi_arready = 1'b0;
          if (!early) begin
            for (int i = 0; i < sl_r_dly; i++) begin @(posedge clock); #1; end
            m_axi_rvalid = 1'b1; m_axi_rdata = sl_mem[idx]; m_axi_rresp = sl_rresp;
          end
          for (int k = 0; k < 30; k++) begin
            if (m_axi_rready) begin @(posedge clock); #1; break; end
            @(posedge clock); #1;
          end
          m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    logic acc;
    acc = 1'b0;
    i_cmd_valid = 1'b1; i_cmd_wr = wr; i_cmd_addr = addr; i_cmd_wdata = data;
    for (int k = 0; k < 50 && !acc; k++) begin
      if (o_cmd_ready) acc = 1'b1;
      @(posedge clock); #1;
    end
    i_cmd_valid = 1'b0; i_cmd_wr = 1'b0; i_cmd_addr = '0; i_cmd_wdata = '0;
    chk("cmd_accept", acc, 1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!o_rsp_valid && lat < 100) begin @(posedge clock); #1; lat++; end
    chk("rsp_arrive", o_rsp_valid, 1);
  endtask

  task automatic consume();
    i_rsp_ready = 1'b1;
    @(posedge clock); #1;
    i_rsp_ready = 1'b0;
    chk("rsp_drop", o_rsp_valid, 0);
    chk("cmd_ready_back", o_cmd_ready, 1);
  endtask

  // One command end to end, checked against the register-level reference.
  task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input int hold, output int lat);
    logic [1:0]    exp_resp;
    logic [DW-1:0] exp_rdata;
    exp_resp  = wr ? sl_bresp : sl_rresp;
    exp_rdata = wr ? '0 : ref_mem[addr[3:2]];
    issue(wr, addr, data);
    wait_rsp(lat);
    for (int i = 0; i < hold; i++) begin @(posedge clock); #1; end
    chk("rsp_valid_hold", o_rsp_valid, 1);
    chk("rsp_wr", o_rsp_wr, wr);
    chk("rsp_rdata", o_rsp_rdata, exp_rdata);
    chk("rsp_resp", o_rsp_resp, exp_resp);
    chk("rsp_timeout", o_rsp_timeout, 0);
    consume();
    if (wr && exp_resp == 2'b00) ref_mem[addr[3:2]] = data;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int lat, n, acks, seen;
    logic aw_s [6], w_s [6], b_s [6];
    logic aw_e [6], w_e [6], b_e [6];
    logic wr;
    logic [DW-1:0] d;

    aw_e = '{1, 1, 1, 1, 0, 0};
    w_e  = '{1, 0, 0, 0, 0, 0};
    b_e  = '{0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 4; i++) ref_mem[i] = '0;
    reset = 1'b0; i_cmd_valid = 1'b0; i_cmd_wr = 1'b0; i_cmd_addr = '0;
    i_cmd_wdata = '0; i_rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_cmd_ready", o_cmd_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_rsp_fields", {o_rsp_wr, o_rsp_timeout, o_rsp_resp, o_rsp_rdata}, 0);
    chk("rst_axi_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    chk("rst_axi_addr_data", {m_axi_awaddr, m_axi_araddr, m_axi_wdata}, 0);
    chk("rst_wstrb", m_axi_wstrb, 4'hF);
    reset = 1'b1;
    @(posedge clock); #1;

    // Zero-wait write: awvalid/wvalid at N+1, bready at N+2, rsp at N+3
    issue(1'b1, 16'h0008, 32'h000001B2);
    chk("t1_awvalid", m_axi_awvalid, 1);
    chk("t1_wvalid", m_axi_wvalid, 1);
    chk("t1_awaddr", m_axi_awaddr, 16'h0008);
    chk("t1_wdata", m_axi_wdata, 32'h000001B2);
    chk("t1_busy", o_busy, 1);
    chk("t1_cmd_ready", o_cmd_ready, 0);
    @(posedge clock); #1;
    chk("t1_bready", m_axi_bready, 1);
    chk("t1_aw_w_low", {m_axi_awvalid, m_axi_wvalid}, 0);
    chk("t1_no_rsp_yet", o_rsp_valid, 0);
    @(posedge clock); #1;
    chk("t1_rsp_valid", o_rsp_valid, 1);
    chk("t1_rsp_resp", o_rsp_resp, 2'b00);
    chk("t1_rsp_timeout", o_rsp_timeout, 0);
    chk("t1_rsp_rdata", o_rsp_rdata, 0);
    consume();
    ref_mem[2] = 32'h000001B2;
    chk("t1_cmd_ready_idle", o_busy, 0);
    run_cmd(1'b0, 16'h0008, '0, 0, lat);
    chk("t1_rd_latency", lat, 2);

    // awready 3 cycles late, wready immediate
    sl_aw_dly = 3;
    acks = b_ack_cnt;
    issue(1'b1, 16'h000C, 32'hCAFE0001);
    for (int k = 0; k < 6; k++) begin
      aw_s[k] = m_axi_awvalid; w_s[k] = m_axi_wvalid; b_s[k] = m_axi_bready;
      if (k < 5) begin @(posedge clock); #1; end
    end
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t2_awvalid_c%0d", k), aw_s[k], aw_e[k]);
      chk($sformatf("t2_wvalid_c%0d", k), w_s[k], w_e[k]);
      chk($sformatf("t2_bready_c%0d", k), b_s[k], b_e[k]);
    end
    chk("t2_rsp_valid", o_rsp_valid, 1);
    chk("t2_rsp_resp", o_rsp_resp, 2'b00);
    consume();
    ref_mem[3] = 32'hCAFE0001;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      if (o_rsp_valid) seen++;
      @(posedge clock); #1;
    end
    chk("t2_single_rsp", seen, 0);
    chk("t2_b_acks", b_ack_cnt - acks, 1);
    sl_aw_dly = 0;

    // Read with rvalid raised alongside arready
    run_cmd(1'b1, 16'h0000, 32'h00000041, 0, lat);
    sl_early = 1'b1;
    run_cmd(1'b0, 16'h0000, '0, 1, lat);
    chk("t3_early_latency", lat, 2);
    sl_early = 1'b0;

    // Error response pass-through
    sl_bresp = 2'b10;
    run_cmd(1'b1, 16'h0004, 32'h12345678, 0, lat);
    sl_bresp = 2'b00;
    sl_rresp = 2'b11;
    run_cmd(1'b0, 16'h000C, '0, 0, lat);
    sl_rresp = 2'b00;

    // Watchdog on a dead slave
    sl_dead = 1'b1;
    issue(1'b0, 16'h0000, '0);
    n = 0;
    while (m_axi_arvalid && n < 100) begin @(posedge clock); #1; n++; end
    chk("t5_arvalid_cycles", n, TO);
    chk("t5_rsp_valid", o_rsp_valid, 1);
    chk("t5_rsp_resp", o_rsp_resp, 2'b10);
    chk("t5_rsp_timeout", o_rsp_timeout, 1);
    chk("t5_rsp_rdata", o_rsp_rdata, 0);
    chk("t5_rsp_wr", o_rsp_wr, 0);
    consume();
    sl_dead = 1'b0;
    run_cmd(1'b0, 16'h0008, '0, 0, lat);

    // Reset pulse during WR_RESP; the late bvalid must never be acknowledged
    sl_b_dly = 4;
    acks = b_ack_cnt;
    issue(1'b1, 16'h0004, 32'hDEADBEEF);
    n = 0;
    while (!m_axi_bready && n < 20) begin @(posedge clock); #1; n++; end
    chk("t6_reach_wr_resp", m_axi_bready, 1);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    chk("t6_bready_low", m_axi_bready, 0);
    chk("t6_rsp_valid_low", o_rsp_valid, 0);
    chk("t6_cmd_ready", o_cmd_ready, 1);
    chk("t6_busy", o_busy, 0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (m_axi_bready) seen++;
      @(posedge clock); #1;
    end
    chk("t6_bready_never", seen, 0);
    chk("t6_no_b_ack", b_ack_cnt - acks, 0);
    sl_b_dly = 0;
    run_cmd(1'b0, 16'h0004, '0, 0, lat);

    // Randomized traffic
    for (int t = 0; t < 24; t++) begin
      sl_aw_dly = $urandom_range(0, 3);
      sl_w_dly  = $urandom_range(0, 3);
      sl_b_dly  = $urandom_range(0, 3);
      sl_ar_dly = $urandom_range(0, 3);
      sl_r_dly  = $urandom_range(0, 3);
      sl_early  = 1'($urandom_range(0, 1));
      sl_bresp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      sl_rresp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      run_cmd(wr, 16'($urandom_range(0, 3) * 4), d, $urandom_range(0, 2), lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
Single-outstanding AXI4-Lite master that turns a simple user command stream (write or read, address, data) into AXI-Lite transactions and returns one response per command. It sits between a local controller (a CPU-less sequencer or test harness) and the UART register slave. It programs the divisor and frame registers, pushes TX bytes and polls RX data. A watchdog converts a hung slave into an error response.

Parameters:
P_M_AXI_DATA_WIDTH, 32, AXI data width (multiple of 8).
P_M_AXI_ADDR_WIDTH, 16, AXI address width.
P_TIMEOUT_CYCLES, 1024, cycles allowed per transaction before abort. 0 disables the watchdog.

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-low reset.
i_cmd_valid  in  1  command valid.
o_cmd_ready  out  1  command accepted when valid&ready.
i_cmd_wr  in  1  1=write, 0=read.
i_cmd_addr  in  ADDR  byte address.
i_cmd_wdata  in  DATA  write data (ignored for reads).
o_rsp_valid  out  1  response valid.
i_rsp_ready  in  1  response consumed.
o_rsp_wr  out  1  echo of command type.
o_rsp_rdata  out  DATA  read data (0 for writes and timeouts).
o_rsp_resp  out  2  BRESP/RRESP, or SLVERR on timeout.
o_rsp_timeout  out  1  response produced by the watchdog.
o_busy  out  1  state != IDLE.
m_axi_awaddr  out  ADDR
m_axi_awvalid  out  1
m_axi_awready  in  1
m_axi_wdata  out  DATA
m_axi_wstrb  out  DATA/8  constant all-ones.
m_axi_wvalid  out  1
m_axi_wready  in  1
m_axi_bresp  in  2
m_axi_bvalid  in  1
m_axi_bready  out  1
m_axi_araddr  out  ADDR
m_axi_arvalid  out  1
m_axi_arready  in  1
m_axi_rdata  in  DATA
m_axi_rresp  in  2
m_axi_rvalid  in  1
m_axi_rready  out  1

Behaviour:
- Reset: reset and clock are decided as follows: reset reset, synchronous, active-low; clock clock.
  - While reset is low: state=IDLE and all outputs 0, except o_cmd_ready=1 (IDLE) and m_axi_wstrb = all ones.
  - Reset mid-transaction: all valid/ready outputs drop at that edge and any pending response is discarded.
- All outputs are registered. No combinational path runs from AXI inputs to AXI outputs.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE:
  - o_cmd_ready=1.
  - On accept at edge N: latch addr/data/wr and clear o_cmd_ready.
  - A write goes to WR_ADDR_DATA with awvalid=wvalid=1 from cycle N+1.
  - A read goes to RD_ADDR with arvalid=1 from cycle N+1.
- WR_ADDR_DATA:
  - awvalid and wvalid each fall independently after their own handshake. Internal aw_done/w_done flags track completion.
  - When both are done, go to WR_RESP with bready=1.
  - Both handshakes may occur in the same cycle or in either order, any number of cycles apart.
- WR_RESP:
  - On bvalid&bready: capture bresp, bready=0, go to RESP.
  - bvalid is never sampled before WR_RESP.
- RD_ADDR: on arvalid&arready, arvalid=0 and go to RD_DATA with rready=1.
  - rvalid asserted early by the slave is left pending; it is not consumed until RD_DATA.
- RD_DATA: on rvalid&rready, capture rdata/rresp, rready=0, go to RESP.
- RESP:
  - o_rsp_valid=1, with fields stable.
  - On i_rsp_ready: o_rsp_valid=0, return to IDLE with o_cmd_ready=1 on the next cycle.
  - Back-to-back commands are therefore separated by at least one idle cycle.
- Minimum latency: with a zero-wait slave, write accept at N gives o_rsp_valid at N+3, and read accept at N gives o_rsp_valid at N+3.
- Response codes are passed through unmodified (OKAY/EXOKAY/SLVERR/DECERR). No retry.
- Watchdog (P_TIMEOUT_CYCLES>0):
  - A counter clears on leaving IDLE and increments every cycle in the four bus states.
  - When count reaches P_TIMEOUT_CYCLES-1, all AXI valid/ready outputs drop next edge and the FSM enters RESP with resp=2'b10, timeout=1, rdata=0.
  - This recovery intentionally violates AXI valid-hold. It exists for dead slaves only.
  - The counter is sized $clog2(P_TIMEOUT_CYCLES+1) and must not wrap.
- Address is forwarded unchanged. Unaligned low bits are the caller's responsibility.
- AWPROT/ARPROT are not driven. The slave does not consume them.

Decomposition:
- Package axi_lite_pkg:
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - State enum typedef.
  - UART register offsets: RX=0x0, TX=0x4, DIV=0x8, CFG=0xC.
- Single module. The watchdog counter is small enough to stay inline; no sub-module.

Test Plan:
- Zero-wait slave, write addr 0x0008 data 0x000001B2 -> awvalid/wvalid at N+1, bready at N+2, rsp at N+3 with resp=00, timeout=0, and slave reg2 reads back 0x000001B2.
- awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid holds 4 cycles, bready only after both handshakes, single response.
- Read addr 0x0000 with slave rvalid asserted alongside arready and rdata 0x00000041 -> rsp rdata=0x00000041, resp=00, wr=0.
- Slave returns bresp=2'b10 -> o_rsp_resp=10, timeout=0.
- P_TIMEOUT_CYCLES=16, slave never asserts arready -> arvalid drops after 16 cycles, then rsp resp=10, timeout=1, rdata=0; a following command completes normally.
- Reset low for 1 cycle during WR_RESP -> next cycle bready=0 and o_rsp_valid=0, o_cmd_ready=1; the stale bvalid is never acknowledged.
